// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU operand issue stage and its arithmetic unit.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package alu_issue_pkg;

    // Datapath word carried on operand buses.
    typedef logic [31:0] bus_t;

    // Arithmetic unit operation select; all-zero encoding is ADD.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } ula_oper_t;

endpackage

// File: rtl/alu_issue.sv
// Operand issue stage: selects operand B, forwards writeback data, 2-entry in-order skid buffer.
// Latency: an operation pushed at edge N is presented (out_valid 1) after edge N.
// Backpressure: in_ready = count != 2 (registered only); a pop at full frees a slot the next cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous discard of all buffered entries (wins over push/pop)
//   in_valid/in_ready   decode handshake; in_oper, in_rs_a/b, in_a/b, in_use_imm, in_imm payload
//   fwd_valid/rd/data   writeback bus used for capture and hold forwarding
//   out_valid/out_ready arithmetic-unit handshake; out_a, out_b, out_oper head-entry payload
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  ula_oper_t        in_oper,
    input  logic [REG_W-1:0] in_rs_a,
    input  logic [REG_W-1:0] in_rs_b,
    input  bus_t             in_a,
    input  bus_t             in_b,
    input  logic             in_use_imm,
    input  bus_t             in_imm,
    input  logic             fwd_valid,
    input  logic [REG_W-1:0] fwd_rd,
    input  bus_t             fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output bus_t             out_a,
    output bus_t             out_b,
    output ula_oper_t        out_oper
);

    // Two-slot storage, addressed by head pointer plus occupancy count.
    ula_oper_t        ent_oper    [2];
    bus_t             ent_a       [2];
    bus_t             ent_b       [2];
    logic [REG_W-1:0] ent_rs_a    [2];
    logic [REG_W-1:0] ent_rs_b    [2];
    logic             ent_use_imm [2];

    logic       head;
    logic [1:0] count;

    logic push;
    logic pop;
    logic wr_idx;
    logic fwd_live;
    bus_t cap_a;
    bus_t cap_b;

    logic [1:0] ent_vld;
    logic [1:0] held;
    logic [1:0] hit_a;
    logic [1:0] hit_b;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // (head + count) mod 2; only evaluated as a write target when count < 2.
    assign wr_idx = head ^ count[0];

    // Register 0 is hardwired and never a forwarding source.
    assign fwd_live = fwd_valid && (fwd_rd != '0);

    // Capture-time operand resolution for the incoming operation.
    always_comb begin
        cap_a = in_a;
        if (fwd_live && (fwd_rd == in_rs_a)) begin
            cap_a = fwd_data;
        end
        cap_b = in_b;
        if (in_use_imm) begin
            cap_b = in_imm;
        end else if (fwd_live && (fwd_rd == in_rs_b)) begin
            cap_b = fwd_data;
        end
    end

    // Hold forwarding applies to valid entries that stay in the buffer this cycle;
    // a popped entry leaves with its pre-edge operands.
    always_comb begin
        ent_vld = 2'b00;
        held    = 2'b00;
        hit_a   = 2'b00;
        hit_b   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ent_vld[i] = (count == 2'd2) || ((count == 2'd1) && (head == 1'(i)));
            held[i]    = ent_vld[i] && !(pop && (head == 1'(i)));
            hit_a[i]   = fwd_live && (fwd_rd == ent_rs_a[i]);
            hit_b[i]   = fwd_live && !ent_use_imm[i] && (fwd_rd == ent_rs_b[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                ent_oper[i]    <= OP_ADD;
                ent_a[i]       <= '0;
                ent_b[i]       <= '0;
                ent_rs_a[i]    <= '0;
                ent_rs_b[i]    <= '0;
                ent_use_imm[i] <= 1'b0;
            end
        end else if (flush) begin
            // Payloads are left as they are; only occupancy is discarded.
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            // The push slot is never a held slot, so these writes never collide.
            for (int i = 0; i < 2; i++) begin
                if (held[i] && hit_a[i]) begin
                    ent_a[i] <= fwd_data;
                end
                if (held[i] && hit_b[i]) begin
                    ent_b[i] <= fwd_data;
                end
            end
            if (push) begin
                ent_oper[wr_idx]    <= in_oper;
                ent_a[wr_idx]       <= cap_a;
                ent_b[wr_idx]       <= cap_b;
                ent_rs_a[wr_idx]    <= in_rs_a;
                ent_rs_b[wr_idx]    <= in_rs_b;
                ent_use_imm[wr_idx] <= in_use_imm;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head entry drives the arithmetic unit directly from registers.
    assign out_a    = ent_a[head];
    assign out_b    = ent_b[head];
    assign out_oper = ent_oper[head];

endmodule
